// File: rtl/cnt_ctrl_pkg.sv
// Shared types and default sizing for the counter sequencer.
package cnt_ctrl_pkg;
  localparam int CNT_WIDTH     = 16;
  localparam int CNT_WD_CYCLES = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } cnt_ctrl_state_e;
endpackage

// File: rtl/cnt_ctrl_wd.sv
// Stall watchdog: pulses stall on the WD_CYCLES-th consecutive enabled cycle
// in which the counter value has not moved since the previous cycle.
module cnt_ctrl_wd #(
  parameter int WIDTH     = 16,
  parameter int WD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             enable,
  input  logic             hold,
  input  logic [WIDTH-1:0] cnt_value,
  output logic             stall
);
  localparam int CW = $clog2(WD_CYCLES + 1);

  logic [WIDTH-1:0] r_prev;
  logic [CW-1:0]    r_cnt;
  logic             w_stuck;

  assign w_stuck = enable && !hold && (cnt_value == r_prev);
  assign stall   = w_stuck && (r_cnt == CW'(WD_CYCLES - 1));

  // Previous value is sampled every cycle so the first RUN cycle compares
  // against the value seen during SETTLE.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= cnt_value;
      if (w_stuck && !stall) r_cnt <= r_cnt + 1'b1;
      else                   r_cnt <= '0;
    end
  end
endmodule

// File: rtl/counter_ctrl.sv
// Command-driven sequencer for an up/down counter: load, run to target, report.
// Optional abort input enabled by defining CNT_CTRL_ABORT_EN.
module counter_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int WIDTH     = CNT_WIDTH,
  parameter int WD_CYCLES = CNT_WD_CYCLES
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             cmd_dir,
  input  logic             hold,
  input  logic [WIDTH-1:0] cnt_value,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef CNT_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic [2:0]       dbg_state
);
  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE out of reset.

  cnt_ctrl_state_e  r_state;
  logic [WIDTH-1:0] r_target;
  logic             w_accept;
  logic             w_at_target;
  logic             w_stall;
  logic             w_abort;

`ifdef CNT_CTRL_ABORT_EN
  assign w_abort = abort && (r_state == LOAD || r_state == SETTLE || r_state == RUN);
`else
  assign w_abort = 1'b0;
`endif

  assign w_at_target = (cnt_value == r_target);
  assign cmd_ready   = (r_state == IDLE) && rst_;
  assign w_accept    = cmd_valid && cmd_ready;
  assign count_enb   = (r_state == RUN) && !w_at_target && !hold && !w_abort;
  assign dbg_state   = r_state;

  cnt_ctrl_wd #(
    .WIDTH     (WIDTH),
    .WD_CYCLES (WD_CYCLES)
  ) u_wd (
    .clk       (clk),
    .rst_      (rst_),
    .enable    (count_enb),
    .hold      (hold),
    .cnt_value (cnt_value),
    .stall     (w_stall)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state  <= IDLE;
      r_target <= '0;
      data_in  <= '0;
      ld_cnt   <= 1'b1;
      updn_cnt <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        ld_cnt  <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_target <= cmd_target;
              data_in  <= cmd_start;
              updn_cnt <= cmd_dir;
              ld_cnt   <= 1'b0;
              busy     <= 1'b1;
              err      <= 1'b0;
              r_state  <= LOAD;
            end
          end
          LOAD: begin
            ld_cnt  <= 1'b1;
            r_state <= SETTLE;
          end
          SETTLE: r_state <= RUN;
          RUN: begin
            // Target check has priority so count_enb is never high at the target.
            if (w_at_target) begin
              done    <= 1'b1;
              r_state <= DONE;
            end else if (w_stall) begin
              err     <= 1'b1;
              r_state <= ERR;
            end
          end
          DONE, ERR: begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            busy    <= 1'b0;
            ld_cnt  <= 1'b1;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a behavioural up/down counter attached.
module tb_counter_ctrl;
  import cnt_ctrl_pkg::*;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_;
  logic         cmd_valid, cmd_ready, cmd_dir, hold;
  logic [W-1:0] cmd_start, cmd_target, cnt_value, data_in;
  logic         ld_cnt, updn_cnt, count_enb, busy, done, err;
  logic [2:0]   dbg_state;

  counter_ctrl #(.WIDTH(W), .WD_CYCLES(8)) dut (
    .clk(clk), .rst_(rst_), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_target(cmd_target), .cmd_dir(cmd_dir),
    .hold(hold), .cnt_value(cnt_value), .data_in(data_in), .ld_cnt(ld_cnt),
    .updn_cnt(updn_cnt), .count_enb(count_enb), .busy(busy), .done(done),
    .err(err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural counter, optionally overridden by a tied value
  logic [W-1:0] model_q = '0;
  logic         tie_en  = 1'b0;
  logic [W-1:0] tie_val = '0;
  always @(posedge clk) begin
    if (ld_cnt === 1'b0)         model_q <= data_in;
    else if (count_enb === 1'b1) model_q <= updn_cnt ? model_q + 1'b1 : model_q - 1'b1;
  end
  assign cnt_value = tie_en ? tie_val : model_q;

  int cyc = 0, enb_total = 0, ld_total = 0;
  logic [W-1:0] ld_data = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (count_enb === 1'b1) enb_total <= enb_total + 1;
    if (ld_cnt === 1'b0) begin
      ld_total <= ld_total + 1;
      ld_data  <= data_in;
    end
  end

  int vectors = 0, miscompares = 0;
  int acc_edge, acc_enb, acc_ld;

  // driver tasks
  task automatic issue_cmd(input logic [W-1:0] s, input logic [W-1:0] t, input logic d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = s; cmd_target = t; cmd_dir = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    acc_edge = cyc; acc_enb = enb_total; acc_ld = ld_total;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done === 1'b1 || err === 1'b1) begin
        lat = cyc - 1 - acc_edge;
        break;
      end
    end
    if (lat < 0) begin
      vectors++; miscompares++;
      $display("FAIL done_timeout: no done/err within 60 cycles");
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b0; cmd_valid = 1'bx; cmd_start = 'x; cmd_target = 'x; cmd_dir = 1'bx; hold = 1'bx;
    #12;
    vectors++; if (ld_cnt !== 1'b1)    begin miscompares++; $display("FAIL rst_ld_cnt: got %b want 1", ld_cnt); end
    vectors++; if (count_enb !== 1'b0) begin miscompares++; $display("FAIL rst_count_enb: got %b want 0", count_enb); end
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (err !== 1'b0)       begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    vectors++; if (done !== 1'b0)      begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
    vectors++; if (updn_cnt !== 1'b1 || data_in !== 16'h0) begin miscompares++; $display("FAIL rst_updn_data: got %b/%h want 1/0000", updn_cnt, data_in); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_low: got %b want 0", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_start = '0; cmd_target = '0; cmd_dir = 1'b1; hold = 1'b0;
    rst_ = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_high: got %b want 1", cmd_ready); end
  endtask

  task automatic test_up_count();
    int lat;
    issue_cmd(16'd5, 16'd10, 1'b1);
    wait_done(lat);
    vectors++; if (lat != 8)                  begin miscompares++; $display("FAIL up_latency: got %0d want 8", lat); end
    vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL up_done_err: got %b/%b want 1/0", done, err); end
    vectors++; if (enb_total - acc_enb != 5)  begin miscompares++; $display("FAIL up_enb_cycles: got %0d want 5", enb_total - acc_enb); end
    vectors++; if (ld_total - acc_ld != 1)    begin miscompares++; $display("FAIL up_ld_cycles: got %0d want 1", ld_total - acc_ld); end
    vectors++; if (ld_data !== 16'd5)         begin miscompares++; $display("FAIL up_ld_data: got %h want 0005", ld_data); end
    vectors++; if (cnt_value !== 16'd10)      begin miscompares++; $display("FAIL up_final: got %h want 000a", cnt_value); end
    @(negedge clk);
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL up_pulse_end: done/busy got %b/%b want 0/0", done, busy); end
  endtask

  task automatic test_down_wrap();
    int lat;
    issue_cmd(16'd2, 16'hFFFE, 1'b0);
    wait_done(lat);
    vectors++; if (lat != 7)                 begin miscompares++; $display("FAIL down_latency: got %0d want 7", lat); end
    vectors++; if (enb_total - acc_enb != 4) begin miscompares++; $display("FAIL down_enb_cycles: got %0d want 4", enb_total - acc_enb); end
    vectors++; if (cnt_value !== 16'hFFFE)   begin miscompares++; $display("FAIL down_final: got %h want fffe", cnt_value); end
    vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL down_done_err: got %b/%b want 1/0", done, err); end
  endtask

  task automatic test_hold();
    int lat, n;
    issue_cmd(16'd0, 16'd4, 1'b1);
    n = 0;
    while (cnt_value !== 16'd2 && n < 30) begin
      @(negedge clk);
      n++;
    end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      vectors++; if (count_enb !== 1'b0) begin miscompares++; $display("FAIL hold_masks_enb[%0d]: got %b want 0", k, count_enb); end
    end
    @(negedge clk);
    hold = 1'b0;
    wait_done(lat);
    vectors++; if (lat != 10)                begin miscompares++; $display("FAIL hold_latency: got %0d want 10", lat); end
    vectors++; if (enb_total - acc_enb != 4) begin miscompares++; $display("FAIL hold_enb_cycles: got %0d want 4", enb_total - acc_enb); end
    vectors++; if (err !== 1'b0 || cnt_value !== 16'd4) begin miscompares++; $display("FAIL hold_err_final: got %b/%h want 0/0004", err, cnt_value); end
  endtask

  task automatic test_stall();
    int lat;
    tie_val = 16'd7; tie_en = 1'b1;
    issue_cmd(16'd0, 16'd9, 1'b1);
    wait_done(lat);
    vectors++; if (err !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL stall_err_done: got %b/%b want 1/0", err, done); end
    vectors++; if (lat != 10)                begin miscompares++; $display("FAIL stall_latency: got %0d want 10", lat); end
    vectors++; if (enb_total - acc_enb != 8) begin miscompares++; $display("FAIL stall_enb_cycles: got %0d want 8", enb_total - acc_enb); end
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL stall_idle: ready/busy got %b/%b want 1/0", cmd_ready, busy); end
    repeat (3) @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL stall_sticky: got %b want 1", err); end
    tie_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat, n;
    issue_cmd(16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 16'd3; cmd_target = 16'd5; cmd_dir = 1'b1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL b2b_err_cleared: got %b want 0", err); end
    lat = -1;
    for (n = 1; n < 20; n++) begin
      vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_busy: got %b want 0", cmd_ready); end
      if (done === 1'b1) begin lat = cyc - 1 - acc_edge; break; end
      @(negedge clk);
    end
    vectors++; if (lat != 3)               begin miscompares++; $display("FAIL eq_latency: got %0d want 3", lat); end
    vectors++; if (enb_total != acc_enb)   begin miscompares++; $display("FAIL eq_enb_cycles: got %0d want 0", enb_total - acc_enb); end
    @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1)     begin miscompares++; $display("FAIL b2b_ready_idle: got %b want 1", cmd_ready); end
    @(posedge clk);
    acc_edge = cyc; acc_enb = enb_total;
    #1 cmd_valid = 1'b0;
    wait_done(lat);
    vectors++; if (lat != 5)               begin miscompares++; $display("FAIL b2b_latency: got %0d want 5", lat); end
    vectors++; if (cnt_value !== 16'd5 || enb_total - acc_enb != 2) begin miscompares++; $display("FAIL b2b_final: got %h/%0d want 0005/2", cnt_value, enb_total - acc_enb); end
  endtask

  task automatic test_reset_mid();
    issue_cmd(16'd0, 16'd100, 1'b1);
    repeat (5) @(negedge clk);
    rst_ = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || ld_cnt !== 1'b1 || count_enb !== 1'b0) begin miscompares++; $display("FAIL mid_reset: busy/ld/enb got %b/%b/%b want 0/1/0", busy, ld_cnt, count_enb); end
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mid_reset_ready: got %b want 1", cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_hold();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Command-driven sequencer that sits on the driving side of the 16-bit up/down counter.
- Accepts a (start, target, direction) command over a valid/ready handshake.
- Drives the counter's load, direction and enable inputs, then watches the counter's output until it reaches the target.
- Reports completion, or a stall error if the counter stops moving.

Parameters:
- WIDTH, 16: counter data width.
- WD_CYCLES, 8: consecutive enabled cycles with an unchanged counter value before a stall error is flagged.

Ports:
- clk  in  1  single clock, rising edge.
- rst_  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_start  in  WIDTH  value loaded into the counter.
- cmd_target  in  WIDTH  value at which counting stops.
- cmd_dir  in  1  1 = count up, 0 = count down.
- hold  in  1  pauses counting while high; state is kept.
- cnt_value  in  WIDTH  counter data_out.
- data_in  out  WIDTH  to counter data_in.
- ld_cnt  out  1  to counter; active-low load.
- updn_cnt  out  1  to counter; 1 = up.
- count_enb  out  1  to counter; active-high count enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the target is reached.
- err  out  1  sticky stall flag; cleared when the next command is accepted.

Behaviour:
- Reset state, applied immediately on rst_ low:
  - State IDLE.
  - ld_cnt=1, count_enb=0, updn_cnt=1, data_in=0.
  - busy=0, done=0, err=0.
  - cmd_ready=1 once rst_ is high.
- Counter assumptions:
  - The counter loads data_in on the clock edge where ld_cnt=0.
  - It counts ±1 on the edge where count_enb=1.
  - cnt_value reflects the edge one cycle later.
  - It wraps modulo 2^WIDTH.
- Handshake:
  - A command is accepted on the edge where cmd_valid && cmd_ready.
  - cmd_start, cmd_target and cmd_dir are registered on that edge.
  - Accepting a command clears err.
- FSM states: IDLE, LOAD, SETTLE, RUN, DONE, ERR.
  - IDLE: on accept, go to LOAD.
  - LOAD: exactly one cycle. ld_cnt=0, data_in=start_q, updn_cnt=dir_q, count_enb=0. Next state is SETTLE.
  - SETTLE: one cycle. ld_cnt=1. Lets cnt_value reflect start_q. Next state is RUN.
  - RUN:
    - updn_cnt=dir_q.
    - count_enb is combinational: (cnt_value != target_q) && !hold.
    - When cnt_value == target_q, go to DONE, so count_enb is never asserted at the target.
  - DONE: done=1 for one cycle. Next state is IDLE.
  - ERR: err=1, latched. Next state is IDLE on the following cycle.
- Step counting:
  - Steps taken = (target − start) mod 2^WIDTH for up, (start − target) mod 2^WIDTH for down.
  - Wrap-around through 0xFFFF/0x0000 is legal and not an error.
- Equal start and target: zero enabled cycles. done is asserted 3 cycles after accept (LOAD, SETTLE, RUN detects the match, DONE).
- Stall watchdog:
  - In RUN, a cycle counts toward the stall when count_enb=1 and cnt_value equals its previous-cycle value.
  - WD_CYCLES such consecutive cycles → ERR.
  - Any hold cycle or any change in cnt_value resets the stall count.
  - hold=1 never triggers a stall.
- Hold timing: hold only masks count_enb in RUN; it has no effect in LOAD or SETTLE.
- Reset mid-operation: outputs and state return to reset values asynchronously. The counter is not reloaded.
- Outputs: all are registered except count_enb and cmd_ready, which are decoded from state plus the inputs listed above.

Optional Feature:
CNT_CTRL_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD, SETTLE or RUN → forces count_enb=0 that cycle and goes to IDLE next edge.
  - No done pulse, err unchanged.
- Undefined: no abort port; a command always runs to DONE or ERR.

Decomposition:
- Package cnt_ctrl_pkg holds:
  - state enum cnt_ctrl_state_e: IDLE, LOAD, SETTLE, RUN, DONE, ERR.
  - Default WIDTH and WD_CYCLES localparams.
- Sub-module cnt_ctrl_wd: the stall watchdog.
  - Inputs: clk, rst_, enable, hold, cnt_value.
  - Output: stall pulse.
  - Instantiated once.

Test Plan:
1. Reset: rst_=0 with X inputs → ld_cnt=1, count_enb=0, busy=0, err=0, done=0. After release, cmd_ready=1.
2. Up count: start=5, target=10, dir=1 with a real counter attached → one ld_cnt=0 cycle with data_in=5, then exactly 5 count_enb cycles. cnt_value=10 and done pulses once, 8 cycles after accept.
3. Down wrap: start=2, target=0xFFFE, dir=0 → 4 enabled cycles through 0x0000. Final cnt_value=0xFFFE, done=1, err=0.
4. Hold: start=0, target=4, hold high for 3 cycles mid-RUN → count_enb low during hold. Total enabled cycles = 4, done 3 cycles later than without hold, no err.
5. Stall: cnt_value tied to 7, target=9 → ERR after WD_CYCLES=8 enabled cycles. err stays high until the next accept; cmd_ready returns to 1.
6. Equal values and back-to-back: start=target=0x1234 → zero count_enb cycles, done 3 cycles after accept. A second command presented during busy is not accepted (cmd_ready=0) until IDLE.
